fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 16-bit accumulator CPU. It sits between the byte-wide instruction memory and the instruction register / control decode. It holds the program counter and reads each 16-bit little-endian instruction as two byte reads. It presents the assembled instruction with a valid/ready handshake and supports jump redirect and halt.

## Interface
- IMEM_AW, 14: instruction memory byte-address width (16 Ki bytes).
- RESET_PC, 16'h0000: PC value loaded on reset. Bit 0 must be 0.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  IMEM_AW  byte address presented to instruction memory.
- imem_rd  out  1  read strobe. Data returns on imem_rdata in the next cycle.
- imem_rdata  in  8  read data, valid one cycle after imem_rd.
- instr  out  16  assembled instruction {high byte, low byte}.
- instr_pc  out  16  byte address of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  consumer accepts when instr_valid & instr_ready.
- redirect  in  1  one-cycle jump request.
- redirect_addr  in  16  jump target byte address. Bit 0 is forced to 0.
- halt  in  1  pulse; stop fetching after the current instruction.
- halted  out  1  high while in S_HALT.
- pc_wrap  out  1  one-cycle pulse when the PC wraps 16'hFFFE -> 16'h0000.

## Operation
- States: S_LO, S_HI, S_ASM, S_OUT, S_HALT.
- **S_LO**
  - If halt_pending: go to S_HALT; imem_rd = 0.
  - Else: imem_rd = 1, imem_addr = pc[IMEM_AW-1:0]; go to S_HI.
- **S_HI**
  - imem_rd = 1, imem_addr = pc[IMEM_AW-1:0] + 1. PC is always even, so this never carries.
  - lo_byte <= imem_rdata; go to S_ASM.
- **S_ASM**
  - instr <= {imem_rdata, lo_byte}, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc + 2, mod 2^16. pc_wrap pulses if pc was 16'hFFFE.
  - Go to S_OUT.
- **S_OUT**
  - No memory reads.
  - On instr_valid & instr_ready: instr_valid <= 0; go to S_LO.
- **S_HALT**
  - No reads; halted = 1.
  - Exit only via redirect or reset.
- imem_rd and imem_addr are decoded from state only; imem_rd = 0 in S_ASM, S_OUT, S_HALT and while reset is high.
- **redirect** (any state, highest priority):
  - pc <= {redirect_addr[15:1], 1'b0}, instr_valid <= 0, next state S_LO.
  - Any read in flight or issued in that cycle is discarded.
  - If instr_valid & instr_ready in the same cycle, that transfer counts as completed before the flush.
- **halt_pending**: halt_pending <= halt | (halt_pending & ~redirect). If halt and redirect arrive together, the halt wins: the redirect target is loaded but not fetched.
- A halt during S_HI, S_ASM or S_OUT lets the current instruction complete and be delivered. The stop takes effect at the next S_LO.
- Reset values:
  - pc = RESET_PC, state = S_LO.
  - instr = 0, instr_pc = 0, lo_byte = 0.
  - instr_valid = 0, halted = 0, pc_wrap = 0, halt_pending = 0.
- Reset mid-fetch abandons the partial instruction. No output glitches beyond the async clear.

## Timing
- First fetch: imem_rd in the first cycle after reset deasserts (cycle 0).
- instr_valid rises at the edge ending cycle 2. Latency is 3 cycles from the S_LO read to valid.
- Peak throughput is 1 instruction per 4 cycles (S_LO, S_HI, S_ASM, S_OUT with ready high).
- Backpressure: instr, instr_pc and instr_valid stay stable while instr_valid & ~instr_ready.
- Redirect: the read at the new target is issued the cycle after redirect. The new instruction is valid 3 cycles after that read.
- pc_wrap is registered and asserted for exactly one cycle, aligned with instr_valid rising.

## Structure
- Shared package cpu_pkg:
  - fetch state enum (S_LO..S_HALT);
  - INSTR_W = 16;
  - IMEM_AW default;
  - RESET_PC default.
- Single flat module; no sub-module needed. The PC, byte latch and output register are all local.

## Test plan
- Memory[0]=8'h34, [1]=8'h12, ready=1, release reset → imem_rd at addr 0 then 1; instr=16'h1234, instr_pc=0 valid in cycle 3; next read at addr 2.
- Hold ready=0 for 5 cycles with valid high → instr/instr_pc unchanged, imem_rd=0 throughout; ready=1 → single transfer, then a read at pc+2.
- redirect with redirect_addr=16'h0101 during S_HI → partial fetch discarded, no valid; next read at byte 0x0100; instr_pc=16'h0100.
- redirect to 16'hFFFE → reads at 0x3FFE/0x3FFF, instr_pc=16'hFFFE, pc_wrap pulses once, next fetch at 0x0000.
- halt pulse in S_HI → current instr delivered, then halted=1 and no imem_rd for 20 cycles; redirect to 16'h0010 → halted=0, read at 0x0010.
- Async reset asserted mid-S_HI (between edges) → instr_valid=0, halted=0 immediately; after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: fetch state encoding and
// default sizing of the instruction path.
`timescale 1ns/1ps
package cpu_pkg;

    typedef enum logic [2:0] {
        S_LO   = 3'd0,
        S_HI   = 3'd1,
        S_ASM  = 3'd2,
        S_OUT  = 3'd3,
        S_HALT = 3'd4
    } fetch_state_t;

    localparam int          INSTR_W          = 16;
    localparam int          DEFAULT_IMEM_AW  = 14;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads each little-endian 16-bit instruction as two
// byte reads and hands it to decode over a valid/ready handshake.
`timescale 1ns/1ps
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          IMEM_AW  = DEFAULT_IMEM_AW,
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_rd,
    input  logic [7:0]         imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [15:0]        redirect_addr,
    input  logic               halt,
    output logic               halted,
    output logic               pc_wrap
);

    fetch_state_t state;
    fetch_state_t state_seq;
    fetch_state_t state_nxt;
    logic [15:0]  pc;
    logic [7:0]   lo_byte;
    logic         halt_pending;
    logic         transfer;

    assign transfer  = instr_valid & instr_ready;
    // A redirect overrides whatever the sequencer wanted to do this cycle.
    assign state_nxt = redirect ? S_LO : state_seq;

    // Next-state sequencing of the two-byte fetch.
    always_comb begin
        state_seq = state;
        case (state)
            S_LO: begin
                if (halt_pending) begin
                    state_seq = S_HALT;
                end else begin
                    state_seq = S_HI;
                end
            end
            S_HI:   state_seq = S_ASM;
            S_ASM:  state_seq = S_OUT;
            S_OUT: begin
                if (transfer) begin
                    state_seq = S_LO;
                end else begin
                    state_seq = S_OUT;
                end
            end
            S_HALT: state_seq = S_HALT;
            default: state_seq = S_LO;
        endcase
    end

    // Memory strobe and address decoded from the current state.
    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = pc[IMEM_AW-1:0];
        case (state)
            S_LO: begin
                imem_rd = ~halt_pending & ~reset;
            end
            S_HI: begin
                imem_rd   = ~reset;
                imem_addr = pc[IMEM_AW-1:0] | {{(IMEM_AW-1){1'b0}}, 1'b1};
            end
            default: begin
                imem_rd = 1'b0;
            end
        endcase
    end

    // PC, byte latch, output register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LO;
            pc           <= RESET_PC;
            lo_byte      <= 8'h00;
            instr        <= {INSTR_W{1'b0}};
            instr_pc     <= 16'h0000;
            instr_valid  <= 1'b0;
            halt_pending <= 1'b0;
            halted       <= 1'b0;
            pc_wrap      <= 1'b0;
        end else begin
            state        <= state_nxt;
            halt_pending <= halt | (halt_pending & ~redirect);
            halted       <= (state_nxt == S_HALT);
            pc_wrap      <= 1'b0;
            if (redirect) begin
                pc          <= {redirect_addr[15:1], 1'b0};
                instr_valid <= 1'b0;
            end else begin
                case (state)
                    S_HI: begin
                        lo_byte <= imem_rdata;
                    end
                    S_ASM: begin
                        instr       <= {imem_rdata, lo_byte};
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 16'd2;
                        pc_wrap     <= (pc == 16'hFFFE);
                    end
                    S_OUT: begin
                        if (transfer) begin
                            instr_valid <= 1'b0;
                        end else begin
                            instr_valid <= instr_valid;
                        end
                    end
                    default: begin
                        lo_byte <= lo_byte;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected transfers, monitors
// compare every handshake, read strobe and wrap pulse against them.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] imem_addr;
    logic          imem_rd;
    logic [7:0]    imem_rdata;
    logic [15:0]   instr;
    logic [15:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [15:0]   redirect_addr;
    logic          halt;
    logic          halted;
    logic          pc_wrap;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } xfer_t;

    logic [7:0]    mem [0:(1<<AW)-1];
    xfer_t         exp_q[$];
    logic [AW-1:0] rd_log[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            wrap_cnt = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .halted(halted), .pc_wrap(pc_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int got);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d, expected 0", name, got);
    endtask

    // Transfer monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        xfer_t e;
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_xfer: got %0h@%0h, expected none", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("xfer_instr", {16'h0000, instr}, {16'h0000, e.instr});
                check("xfer_pc", {16'h0000, instr_pc}, {16'h0000, e.pc});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && pc_wrap) begin
            wrap_cnt++;
            check("wrap_with_valid", {31'd0, instr_valid}, 32'd1);
            check("wrap_pc", {16'h0000, instr_pc}, 32'h0000FFFE);
        end
    end

    always @(negedge clk) begin
        if (imem_rd) rd_log.push_back(imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (exp_q.size() != 0 && k < max) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!instr_valid && k < max) begin
            tick();
            k++;
        end
        if (!instr_valid) fail_now("valid_timeout", k);
    endtask

    task automatic check_rd(input string name, input int idx, input logic [AW-1:0] exp);
        if (idx < rd_log.size()) begin
            check(name, {18'd0, rd_log[idx]}, {18'd0, exp});
        end else begin
            fail_now(name, idx);
        end
    endtask

    task automatic check_read_now(input string name, input logic [AW-1:0] exp);
        check({name, "_rd"}, {31'd0, imem_rd}, 32'd1);
        check({name, "_addr"}, {18'd0, imem_addr}, {18'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[14'h0000] = 8'h34; mem[14'h0001] = 8'h12;
        mem[14'h0002] = 8'h78; mem[14'h0003] = 8'h56;
        mem[14'h0004] = 8'hBC; mem[14'h0005] = 8'h9A;
        mem[14'h0010] = 8'hAD; mem[14'h0011] = 8'hDE;
        mem[14'h0012] = 8'h55; mem[14'h0013] = 8'h66;
        mem[14'h0100] = 8'h11; mem[14'h0101] = 8'h22;
        mem[14'h3FFE] = 8'hEF; mem[14'h3FFF] = 8'hBE;
        instr_ready   = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        halt          = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rd", {31'd0, imem_rd}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_wrap", {31'd0, pc_wrap}, 32'd0);
        check("rst_instr", {16'h0000, instr}, 32'd0);
        check("rst_instr_pc", {16'h0000, instr_pc}, 32'd0);

        // First fetch and 3-cycle latency
        exp_q.push_back('{instr: 16'h1234, pc: 16'h0000});
        reset = 1'b0;
        #1;
        check_read_now("first_lo", 14'h0000);
        tick();
        check("lat_c1", {31'd0, instr_valid}, 32'd0);
        check_read_now("first_hi", 14'h0001);
        tick();
        check("lat_c2", {31'd0, instr_valid}, 32'd0);
        tick();
        check("lat_c3", {31'd0, instr_valid}, 32'd1);
        check("lat_instr", {16'h0000, instr}, 32'h00001234);
        tick();
        check_read_now("next_lo", 14'h0002);

        // Backpressure: five stalled cycles, then a single transfer
        instr_ready = 1'b0;
        exp_q.push_back('{instr: 16'h5678, pc: 16'h0002});
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", {16'h0000, instr}, 32'h00005678);
            check("bp_pc", {16'h0000, instr_pc}, 32'h00000002);
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_no_rd", {31'd0, imem_rd}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("bp_drop", {31'd0, instr_valid}, 32'd0);
        check("bp_q_empty", exp_q.size(), 32'd0);
        check_read_now("bp_resume", 14'h0004);

        // Redirect during S_HI discards the partial fetch
        tick();
        check("in_hi_addr", {18'd0, imem_addr}, 32'h00000005);
        redirect = 1'b1;
        redirect_addr = 16'h0101;
        tick();
        redirect = 1'b0;
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        check_read_now("redir_lo", 14'h0100);
        exp_q.push_back('{instr: 16'h2211, pc: 16'h0100});
        wait_drain(20);
        instr_ready = 1'b0;

        // Wrap at the top of the PC range
        redirect = 1'b1;
        redirect_addr = 16'hFFFE;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        rd_log.delete();
        wrap_cnt = 0;
        exp_q.push_back('{instr: 16'hBEEF, pc: 16'hFFFE});
        wait_drain(20);
        instr_ready = 1'b0;
        repeat (3) tick();
        check_rd("wrap_rd0", 0, 14'h3FFE);
        check_rd("wrap_rd1", 1, 14'h3FFF);
        check_rd("wrap_rd2", 2, 14'h0000);
        check("wrap_once", wrap_cnt, 32'd1);

        // Halt during S_HI: current instruction completes, then stop
        redirect = 1'b1;
        redirect_addr = 16'h0004;
        tick();
        redirect = 1'b0;
        check_read_now("halt_lo", 14'h0004);
        tick();
        check_read_now("halt_hi", 14'h0005);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        exp_q.push_back('{instr: 16'h9ABC, pc: 16'h0004});
        instr_ready = 1'b1;
        wait_drain(20);
        check("halt_lo_no_rd", {31'd0, imem_rd}, 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            check("halted_hi", {31'd0, halted}, 32'd1);
            check("halted_no_rd", {31'd0, imem_rd}, 32'd0);
            tick();
        end
        exp_q.push_back('{instr: 16'hDEAD, pc: 16'h0010});
        redirect = 1'b1;
        redirect_addr = 16'h0010;
        tick();
        redirect = 1'b0;
        check("unhalt", {31'd0, halted}, 32'd0);
        check_read_now("unhalt_lo", 14'h0010);
        wait_drain(20);
        instr_ready = 1'b0;

        // Asynchronous reset in the middle of S_HI
        wait_valid(10);
        check("stall_instr", {16'h0000, instr}, 32'h00006655);
        redirect = 1'b1;
        redirect_addr = 16'h0002;
        tick();
        redirect = 1'b0;
        tick();
        check("pre_rst_hi", {18'd0, imem_addr}, 32'h00000003);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_instr", {16'h0000, instr}, 32'd0);
        check("arst_rd", {31'd0, imem_rd}, 32'd0);
        tick();
        exp_q.push_back('{instr: 16'h1234, pc: 16'h0000});
        instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        check_read_now("restart", 14'h0000);
        wait_drain(20);
        instr_ready = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
